// File: rtl/tetris_input_pkg.sv
// -----------------------------------------------------------------------------
// tetris_input_pkg
// Shared definitions for the Tetris controller input conditioner:
//   - btn_state_t : per-button debounce / auto-repeat state encoding (3 bits)
//   - BTN_*       : bit positions of each button in the 4-bit button vectors
//   - is_repeatable() : which buttons auto-repeat while held
// No ports (package).
// -----------------------------------------------------------------------------
package tetris_input_pkg;

    typedef enum logic [2:0] {
        IDLE         = 3'd0,
        PRESS_WAIT   = 3'd1,
        HOLD_DELAY   = 3'd2,
        HOLD_REPEAT  = 3'd3,
        RELEASE_WAIT = 3'd4
    } btn_state_t;

    localparam int BTN_LEFT  = 0;
    localparam int BTN_RIGHT = 1;
    localparam int BTN_DOWN  = 2;
    localparam int BTN_ROT   = 3;
    localparam int NUM_BTNS  = BTN_ROT + 1;

    // Movement buttons auto-repeat; rotation fires once per accepted press.
    function automatic bit is_repeatable(input int idx);
        return (idx == BTN_LEFT) || (idx == BTN_RIGHT) || (idx == BTN_DOWN);
    endfunction

endpackage

// File: rtl/input_button_fsm.sv
// -----------------------------------------------------------------------------
// input_button_fsm
// One button channel: 2-flop synchroniser, debounce FSM and auto-repeat timer.
//
// Configuration macro: AUTO_REPEAT_EN
//   defined   -> held movement buttons repeat after REPEAT_DELAY, then every
//                REPEAT_RATE cycles (only when REPEAT_ALLOWED = 1)
//   undefined -> HOLD_DELAY never times out, every button fires once per press
//
// Ports:
//   clock     in  system clock
//   reset_n   in  asynchronous active-low reset
//   i_btn_n   in  raw active-low button
//   o_held    out debounced level, 1 = pressed
//   o_fire    out one-cycle pulse on accepted press or repeat
// -----------------------------------------------------------------------------
module input_button_fsm
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_RATE     = 2500000,
    parameter int CNT_W           = 24,
    parameter bit REPEAT_ALLOWED  = 1'b1
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_btn_n,
    output logic o_held,
    output logic o_fire
);

`ifdef AUTO_REPEAT_EN
    localparam bit AUTO_REPEAT = 1'b1;
`else
    localparam bit AUTO_REPEAT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] DEB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RATE_LAST  = CNT_W'(REPEAT_RATE - 1);

    logic             r_sync1;
    logic             r_sync2;
    btn_state_t       r_state;
    logic [CNT_W-1:0] r_cnt;

    btn_state_t       w_state_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic             w_fire;
    logic             w_pressed;

    // Synchroniser flops idle at 1 (released) so reset never looks like a press.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    assign w_pressed = ~r_sync2;

    // Counter is zeroed on every transition and every fire, so it never wraps.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_fire       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_pressed) begin
                    w_state_next = PRESS_WAIT;
                    w_cnt_next   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!w_pressed) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next = HOLD_DELAY;
                    w_cnt_next   = '0;
                    w_fire       = 1'b1;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            HOLD_DELAY: begin
                if (!w_pressed) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end else if (AUTO_REPEAT) begin
                    if (r_cnt == DELAY_LAST) begin
                        w_state_next = HOLD_REPEAT;
                        w_cnt_next   = '0;
                        w_fire       = REPEAT_ALLOWED;
                    end else begin
                        w_cnt_next   = r_cnt + CNT_W'(1);
                    end
                end
            end
            HOLD_REPEAT: begin
                if (!w_pressed) begin
                    w_state_next = RELEASE_WAIT;
                    w_cnt_next   = '0;
                end else if (r_cnt == RATE_LAST) begin
                    w_cnt_next   = '0;
                    w_fire       = REPEAT_ALLOWED;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            RELEASE_WAIT: begin
                // A re-press before release is confirmed restarts the repeat
                // delay without producing a new event.
                if (w_pressed) begin
                    w_state_next = HOLD_DELAY;
                    w_cnt_next   = '0;
                end else if (r_cnt == DEB_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next   = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    assign o_held = (r_state == HOLD_DELAY) || (r_state == HOLD_REPEAT) ||
                    (r_state == RELEASE_WAIT);
    assign o_fire = w_fire;

endmodule

// File: rtl/tetris_input_conditioner.sv
// -----------------------------------------------------------------------------
// tetris_input_conditioner
// Conditions the four active-low push-buttons (left/right/down/rotate_cw) for
// the processor: per-button synchronise + debounce + auto-repeat, with sticky
// event and overrun flags held until the processor acknowledges them.
//
// Configuration macro: AUTO_REPEAT_EN (enables left/right/down auto-repeat;
// when undefined every button fires once per accepted press).
//
// Ports:
//   clock      in  1  system clock (processor domain)
//   reset_n    in  1  asynchronous active-low reset
//   i_btn_n    in  4  raw buttons, active low; [0]=left [1]=right [2]=down [3]=rot
//   i_ack      in  4  one-cycle pulse per bit, clears event/overrun
//   o_held     out 4  debounced levels (LEDs)
//   o_event    out 4  sticky press/repeat flags
//   o_overrun  out 4  sticky: an event fired while the previous one was pending
// -----------------------------------------------------------------------------
module tetris_input_conditioner
    import tetris_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 10000000,
    parameter int REPEAT_RATE     = 2500000,
    parameter int CNT_W           = 24
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic [NUM_BTNS-1:0] i_btn_n,
    input  logic [NUM_BTNS-1:0] i_ack,
    output logic [NUM_BTNS-1:0] o_held,
    output logic [NUM_BTNS-1:0] o_event,
    output logic [NUM_BTNS-1:0] o_overrun
);

    logic [NUM_BTNS-1:0] w_fire;
    logic [NUM_BTNS-1:0] w_held;
    logic [NUM_BTNS-1:0] w_event_next;
    logic [NUM_BTNS-1:0] w_overrun_next;
    logic [NUM_BTNS-1:0] r_event;
    logic [NUM_BTNS-1:0] r_overrun;

    generate
        for (genvar gi = 0; gi < NUM_BTNS; gi++) begin : g_btn
            input_button_fsm #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .REPEAT_DELAY    (REPEAT_DELAY),
                .REPEAT_RATE     (REPEAT_RATE),
                .CNT_W           (CNT_W),
                .REPEAT_ALLOWED  (is_repeatable(gi))
            ) u_btn (
                .clock   (clock),
                .reset_n (reset_n),
                .i_btn_n (i_btn_n[gi]),
                .o_held  (w_held[gi]),
                .o_fire  (w_fire[gi])
            );
        end
    endgenerate

    // A fire always wins over a same-cycle ack. Overrun only counts a fire
    // landing on a still-pending event that is not being acked this cycle.
    assign w_event_next   = w_fire | (r_event & ~i_ack);
    assign w_overrun_next = (w_fire & r_event & ~i_ack) | (r_overrun & ~i_ack);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_event   <= '0;
            r_overrun <= '0;
        end else begin
            r_event   <= w_event_next;
            r_overrun <= w_overrun_next;
        end
    end

    assign o_held    = w_held;
    assign o_event   = r_event;
    assign o_overrun = r_overrun;

endmodule

// File: tb/tb_tetris_input_conditioner.sv
// -----------------------------------------------------------------------------
// tb_tetris_input_conditioner
// Scoreboard bench: the stimulus process drives inputs on the falling edge and
// pushes the expected post-edge outputs from a behavioural model; a monitor
// pops and compares 1 time unit after every rising edge.
// Model: a button toggles its debounced level once the synchronised input has
// disagreed with it for DEBOUNCE+1 consecutive edges; while held, repeats come
// at REPEAT_DELAY + n*REPEAT_RATE edges after the start of continuous holding.
// -----------------------------------------------------------------------------
module tb_tetris_input_conditioner;

    localparam int D  = 4;
    localparam int RD = 10;
    localparam int RR = 3;
`ifdef AUTO_REPEAT_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] btn_n   = 4'hF;
    logic [3:0] ack     = 4'h0;
    logic [3:0] held;
    logic [3:0] ev;
    logic [3:0] ov;

    always #5 clock = ~clock;

    tetris_input_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .REPEAT_DELAY    (RD),
        .REPEAT_RATE     (RR),
        .CNT_W           (24)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .i_btn_n   (btn_n),
        .i_ack     (ack),
        .o_held    (held),
        .o_event   (ev),
        .o_overrun (ov)
    );

    typedef struct packed {
        logic [3:0] held;
        logic [3:0] ev;
        logic [3:0] ov;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // ---------------- behavioural model ----------------
    bit         m_pipe1 [4];
    bit         m_pipe2 [4];
    bit         m_held  [4];
    bit         m_prev_p[4];
    int         m_mis   [4];
    int         m_age   [4];
    logic [3:0] m_ev;
    logic [3:0] m_ov;
    int         edge_no;

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pipe1[i]  = 1'b0;
            m_pipe2[i]  = 1'b0;
            m_held[i]   = 1'b0;
            m_prev_p[i] = 1'b0;
            m_mis[i]    = 0;
            m_age[i]    = 0;
        end
        m_ev    = 4'h0;
        m_ov    = 4'h0;
    endfunction

    function automatic void model_edge(input logic [3:0] b, input logic [3:0] a);
        logic [3:0] fire;
        exp_t       e;
        bit         p;
        fire = 4'h0;
        for (int i = 0; i < 4; i++) begin
            p          = m_pipe2[i];
            m_pipe2[i] = m_pipe1[i];
            m_pipe1[i] = ~b[i];
            if (p != m_held[i]) m_mis[i]++;
            else                m_mis[i] = 0;
            if (m_mis[i] == D + 1) begin
                m_held[i] = ~m_held[i];
                m_mis[i]  = 0;
                if (m_held[i]) begin
                    fire[i]  = 1'b1;
                    m_age[i] = 0;
                end
            end else if (m_held[i] && p) begin
                if (!m_prev_p[i]) begin
                    m_age[i] = 0;
                end else begin
                    m_age[i]++;
                    if (AUTO && i != 3 && m_age[i] >= RD && ((m_age[i] - RD) % RR) == 0)
                        fire[i] = 1'b1;
                end
            end
            m_prev_p[i] = p;
        end
        m_ov = (fire & m_ev & ~a) | (m_ov & ~a);
        m_ev = fire | (m_ev & ~a);
        e.held = {m_held[3], m_held[2], m_held[1], m_held[0]};
        e.ev   = m_ev;
        e.ov   = m_ov;
        exp_q.push_back(e);
        edge_no++;
        if (fire != 4'h0)
            $display("edge %0d: fire=%b ack=%b -> held=%b event=%b overrun=%b",
                     edge_no, fire, a, e.held, e.ev, e.ov);
    endfunction

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %b required %b at t=%0t", name, act, req, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("held", held, e.held);
                check("event", ev, e.ev);
                check("overrun", ov, e.ov);
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic drive(input logic [3:0] b, input logic [3:0] a);
        btn_n = b;
        ack   = a;
        model_edge(b, a);
        @(negedge clock);
    endtask

    task automatic hold(input logic [3:0] b, input logic [3:0] a, input int n);
        for (int k = 0; k < n; k++) drive(b, a);
    endtask

    initial begin : stim
        logic [3:0] b;
        logic [3:0] a;
        int         rem[4];
        edge_no = 0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        check("reset_held", held, 4'h0);
        check("reset_event", ev, 4'h0);
        check("reset_overrun", ov, 4'h0);
        @(negedge clock);
        reset_n = 1'b1;

        // 1: left held, no ack -> accept then repeats with overrun
        hold(4'b1110, 4'h0, 30);
        hold(4'hF, 4'h0, 10);
        drive(4'hF, 4'hF);
        hold(4'hF, 4'h0, 3);

        // 2: right bounces shorter than debounce -> nothing
        hold(4'b1101, 4'h0, 3);
        hold(4'hF, 4'h0, 1);
        hold(4'b1101, 4'h0, 2);
        hold(4'hF, 4'h0, 10);

        // 3: left + rot together; ack rot on the cycle left repeats
        hold(4'b0110, 4'h0, 16);
        drive(4'b0110, 4'b1000);
        hold(4'b0110, 4'h0, 23);
        hold(4'hF, 4'h0, 10);
        drive(4'hF, 4'hF);
        hold(4'hF, 4'h0, 2);

        // 4: down accepted, acked, brief release inside release window
        hold(4'b1011, 4'h0, 8);
        drive(4'b1011, 4'b0100);
        hold(4'b1011, 4'h0, 3);
        hold(4'hF, 4'h0, 2);
        hold(4'b1011, 4'h0, 20);
        hold(4'hF, 4'h0, 10);
        drive(4'hF, 4'hF);

        // 5: async reset while three buttons are held and events pending
        hold(4'b1000, 4'h0, 25);
        #2 reset_n = 1'b0;
        #1;
        check("async_rst_held", held, 4'h0);
        check("async_rst_event", ev, 4'h0);
        check("async_rst_overrun", ov, 4'h0);
        @(posedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        hold(4'b1000, 4'h0, 12);
        hold(4'hF, 4'h0, 10);
        drive(4'hF, 4'hF);

        // 6: left held long
        hold(4'b1110, 4'h0, 50);
        hold(4'hF, 4'h0, 10);
        drive(4'hF, 4'hF);

        // random: independent buttons with bounces and random acks
        b = 4'hF;
        for (int i = 0; i < 4; i++) rem[i] = $urandom_range(1, 20);
        for (int s = 0; s < 1500; s++) begin
            for (int i = 0; i < 4; i++) begin
                rem[i]--;
                if (rem[i] <= 0) begin
                    b[i]   = ~b[i];
                    rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3)
                                                         : $urandom_range(4, 30);
                end
                a[i] = ($urandom_range(0, 5) == 0);
            end
            drive(b, a);
        end
        hold(4'hF, 4'h0, 12);
        drive(4'hF, 4'hF);

        @(posedge clock);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
